// File: rtl/ooo_resp_pkg.sv
// rtl/ooo_resp_pkg.sv - shared types, constants and helpers for ooo_read_responder
// Purpose: LFSR tap mask, parameterized slot record, priority-encoder helper.
// Ports: none (package).
package ooo_resp_pkg;

    // Right-shift Galois form of x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Packed structs cannot take parameters directly, so the slot record is
    // scoped inside a virtual class and specialised by the user.
    virtual class slot_types #(parameter int ID_W = 4, parameter int CNT_W = 3);
        typedef struct packed {
            logic             valid;
            logic [ID_W-1:0]  id;
            logic [CNT_W-1:0] cnt;
        } slot_t;
    endclass

    // Index of the lowest set bit; 0 when no bit is set, so callers must
    // qualify the result with a reduction-OR of the same vector.
    // Callers supply at most 32 request bits.
    function automatic int lowest_set(input logic [31:0] vec);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/resp_lfsr.sv
// rtl/resp_lfsr.sv - 8-bit Galois LFSR with enable, used as the latency source
// Purpose: advances one step per enabled cycle; reloads SEED on reset.
// Ports: clk, rst (async, active-high), en_i (step), state_o (current state).
module resp_lfsr
    import ooo_resp_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    output logic [7:0] state_o
);

    logic [7:0] r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEED;
        end else if (en_i) begin
            r_state <= {1'b0, r_state[7:1]} ^ (r_state[0] ? LFSR_TAPS : 8'h00);
        end
    end

    assign state_o = r_state;

endmodule

// File: rtl/ooo_read_responder.sv
// rtl/ooo_read_responder.sv - memory-side AR/R responder returning beats out of order
// Purpose: holds up to DEPTH requests, each with an LFSR-drawn latency, and
//          returns R beats as latencies expire.
// Ports: clk, rst (async, active-high);
//        AR: s_arid_i, s_arvalid_i, s_arready_o;
//        R : s_rdata_o, s_rid_o, s_rvalid_o, s_rready_i;
//        outstanding_o = occupied slots (output register excluded).
module ooo_read_responder
    import ooo_resp_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ID_WIDTH    = 4,
    parameter int                    DEPTH       = 4,
    parameter int                    DELAY_BITS  = 3,
    parameter logic [DATA_WIDTH-1:0] DATA_OFFSET = 8'h10,
    parameter logic [7:0]            LFSR_SEED   = 8'hA5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ID_WIDTH-1:0]          s_arid_i,
    input  logic                         s_arvalid_i,
    output logic                         s_arready_o,
    output logic [DATA_WIDTH-1:0]        s_rdata_o,
    output logic [ID_WIDTH-1:0]          s_rid_o,
    output logic                         s_rvalid_o,
    input  logic                         s_rready_i,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding_o
);

    // A zero-width counter is not legal, so DELAY_BITS = 0 keeps one bit
    // that is always loaded with 0.
    localparam int CNT_W = (DELAY_BITS > 0) ? DELAY_BITS : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OUT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = (DATA_WIDTH > ID_WIDTH) ? DATA_WIDTH : ID_WIDTH;

    typedef slot_types#(.ID_W(ID_WIDTH), .CNT_W(CNT_W))::slot_t slot_t;

    slot_t                 r_slots [DEPTH];
    logic                  r_rvalid;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [DEPTH-1:0]      w_free;
    logic [DEPTH-1:0]      w_elig;
    logic [OUT_W-1:0]      w_count;
    logic                  w_ar_hs;
    logic                  w_load;
    logic [IDX_W-1:0]      w_alloc_idx;
    logic [IDX_W-1:0]      w_pick_idx;
    logic [7:0]            w_lfsr;
    logic                  w_lfsr_unused;
    logic [CNT_W-1:0]      w_delay;
    logic [ID_WIDTH-1:0]   w_pick_id;

    always_comb begin
        w_free  = '0;
        w_elig  = '0;
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_free[i] = !r_slots[i].valid;
            w_elig[i] = r_slots[i].valid && (r_slots[i].cnt == '0);
            w_count   = w_count + OUT_W'(r_slots[i].valid);
        end
    end

    // Ready depends on registered slot state only; a slot freed at an edge
    // becomes visible to the AR side after that edge.
    assign s_arready_o = |w_free;
    assign w_ar_hs     = s_arvalid_i && s_arready_o;
    assign w_alloc_idx = IDX_W'(lowest_set(32'(w_free)));

    assign w_load      = (!r_rvalid || s_rready_i) && (|w_elig);
    assign w_pick_idx  = IDX_W'(lowest_set(32'(w_elig)));
    assign w_pick_id   = r_slots[w_pick_idx].id;

    // Stepping only on AR handshakes makes the delay sequence a function of
    // request count alone, independent of R backpressure.
    resp_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .en_i    (w_ar_hs),
        .state_o (w_lfsr)
    );

    assign w_lfsr_unused = ^w_lfsr;

    generate
        if (DELAY_BITS > 0) begin : g_delay
            assign w_delay = w_lfsr[CNT_W-1:0];
        end else begin : g_no_delay
            assign w_delay = '0;
        end
    endgenerate

    // Allocation targets a free slot and the load picks a valid one, so the
    // two never touch the same slot in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_load && (w_pick_idx == IDX_W'(i))) begin
                    r_slots[i].valid <= 1'b0;
                end else if (r_slots[i].valid && (r_slots[i].cnt != '0)) begin
                    r_slots[i].cnt <= r_slots[i].cnt - CNT_W'(1);
                end
                if (w_ar_hs && (w_alloc_idx == IDX_W'(i))) begin
                    r_slots[i].valid <= 1'b1;
                    r_slots[i].id    <= s_arid_i;
                    r_slots[i].cnt   <= w_delay;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
        end else if (w_load) begin
            r_rvalid <= 1'b1;
            r_rid    <= w_pick_id;
            r_rdata  <= DATA_WIDTH'(SUM_W'(w_pick_id) + SUM_W'(DATA_OFFSET));
        end else if (s_rready_i) begin
            r_rvalid <= 1'b0;
        end
    end

    assign s_rvalid_o    = r_rvalid;
    assign s_rid_o       = r_rid;
    assign s_rdata_o     = r_rdata;
    assign outstanding_o = w_count;

endmodule
